// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath blocks: operand/accumulator
// widths and the dot-product sequencer state encoding.
package nn_pkg;

  localparam int DATA_W           = 8;
  localparam int ACC_W            = 24;
  // Longest vector whose all-ones dot product still fits in ACC_W bits.
  localparam int MAC_SAFE_MAX_LEN = 258;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_LAST,
    S_DRAIN,
    S_DONE
  } mac_seq_state_t;

endpackage

// File: rtl/mac_dot_sequencer_if.sv
// Result channel of the dot-product sequencer: valid/ready handshake carrying
// the accumulated result and the length-clamp flag.
interface mac_dot_sequencer_if;
  import nn_pkg::*;

  logic             result_valid;
  logic             result_ready;
  logic [ACC_W-1:0] result_data;
  logic             result_clamped;

  modport master (
    output result_valid,
    output result_data,
    output result_clamped,
    input  result_ready
  );

  modport slave (
    input  result_valid,
    input  result_data,
    input  result_clamped,
    output result_ready
  );

endinterface

// File: rtl/mac_seq_addr_gen.sv
// Operand address generator: latches both bases on load, then issues one read
// per cycle for n elements, flagging the cycle in which the last one goes out.
module mac_seq_addr_gen #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LEN_W-1:0]  n,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] x_base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] x_addr,
  output logic              last
);

  // Reads still to issue after the one currently on the bus.
  logic [LEN_W-1:0] remaining;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en     <= 1'b0;
      w_addr    <= '0;
      x_addr    <= '0;
      remaining <= '0;
    end else if (load) begin
      rd_en     <= 1'b1;
      w_addr    <= w_base;
      x_addr    <= x_base;
      remaining <= n - LEN_W'(1);
    end else if (rd_en) begin
      if (remaining == '0) begin
        rd_en <= 1'b0;
      end else begin
        // Address overflow wraps modulo 2^ADDR_W by construction.
        w_addr    <= w_addr + ADDR_W'(1);
        x_addr    <= x_addr + ADDR_W'(1);
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

  assign last = rd_en && (remaining == '0);

endmodule

// File: rtl/mac_dot_sequencer.sv
// Dot-product controller for a single external 8-bit MAC: fetches operand pairs,
// steers the MAC clear/enable, and returns the 24-bit result over valid/ready.
module mac_dot_sequencer
  import nn_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int MAX_LEN = 256,
  parameter int LEN_W   = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  input  logic [ADDR_W-1:0]    w_base,
  input  logic [ADDR_W-1:0]    x_base,
  output logic                 busy,
  output logic                 w_rd_en,
  output logic [ADDR_W-1:0]    w_addr,
  input  logic [DATA_W-1:0]    w_rd_data,
  output logic                 x_rd_en,
  output logic [ADDR_W-1:0]    x_addr,
  input  logic [DATA_W-1:0]    x_rd_data,
  output logic                 mac_clear,
  output logic                 mac_enable,
  output logic [DATA_W-1:0]    mac_a,
  output logic [DATA_W-1:0]    mac_b,
  input  logic [ACC_W-1:0]     mac_out,
  mac_dot_sequencer_if.master  res
);

  mac_seq_state_t   state_q, state_d;
  logic             accept;
  logic             len_zero;
  logic             len_over;
  logic [LEN_W-1:0] n_clamped;
  logic             rd_en;
  logic             last;
  logic [ACC_W-1:0] result_data_q;
  logic             result_clamped_q;

  assign accept    = (state_q == S_IDLE) && start;
  assign len_zero  = (len == '0);
  assign len_over  = (len > LEN_W'(MAX_LEN));
  assign n_clamped = len_over ? LEN_W'(MAX_LEN) : len;

  mac_seq_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk    (clk),
    .reset  (reset),
    .load   (accept && !len_zero),
    .n      (n_clamped),
    .w_base (w_base),
    .x_base (x_base),
    .rd_en  (rd_en),
    .w_addr (w_addr),
    .x_addr (x_addr),
    .last   (last)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = len_zero ? S_DONE : S_CLEAR;
      S_CLEAR: state_d = last ? S_LAST : S_RUN;
      S_RUN:   if (last) state_d = S_LAST;
      S_LAST:  state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  if (res.result_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      mac_enable       <= 1'b0;
      result_data_q    <= '0;
      result_clamped_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      // Read data returns one cycle after the request; enable follows it.
      mac_enable <= rd_en;
      if (accept) begin
        result_clamped_q <= !len_zero && len_over;
        if (len_zero) result_data_q <= '0;
      end
      // The last product lands in the accumulator at the end of LAST.
      if (state_q == S_DRAIN) result_data_q <= mac_out;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign w_rd_en   = rd_en;
  assign x_rd_en   = rd_en;
  assign mac_clear = reset || (state_q == S_CLEAR);
  assign mac_a     = w_rd_data;
  assign mac_b     = x_rd_data;

  assign res.result_valid   = (state_q == S_DONE);
  assign res.result_data    = result_data_q;
  assign res.result_clamped = result_clamped_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer: operand memories and MAC modelled here, outputs
// compared every cycle against a job-relative timing and arithmetic model.
module tb_mac_dot_sequencer;
  import nn_pkg::*;

  localparam int ADDR_W  = 8;
  localparam int MAX_LEN = 256;
  localparam int LEN_W   = 9;
  localparam int MEM_SZ  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] w_base, x_base;
  logic              busy;
  logic              w_rd_en, x_rd_en;
  logic [ADDR_W-1:0] w_addr, x_addr;
  logic [DATA_W-1:0] w_rd_data = '0;
  logic [DATA_W-1:0] x_rd_data = '0;
  logic              mac_clear, mac_enable;
  logic [DATA_W-1:0] mac_a, mac_b;
  logic [ACC_W-1:0]  mac_acc = '0;

  mac_dot_sequencer_if rif ();

  mac_dot_sequencer #(
    .ADDR_W  (ADDR_W),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len        (len),
    .w_base     (w_base),
    .x_base     (x_base),
    .busy       (busy),
    .w_rd_en    (w_rd_en),
    .w_addr     (w_addr),
    .w_rd_data  (w_rd_data),
    .x_rd_en    (x_rd_en),
    .x_addr     (x_addr),
    .x_rd_data  (x_rd_data),
    .mac_clear  (mac_clear),
    .mac_enable (mac_enable),
    .mac_a      (mac_a),
    .mac_b      (mac_b),
    .mac_out    (mac_acc),
    .res        (rif)
  );

  always #5 clk = ~clk;

  logic [7:0] w_mem [MEM_SZ];
  logic [7:0] x_mem [MEM_SZ];

  always @(posedge clk) begin
    if (w_rd_en) w_rd_data <= w_mem[w_addr];
    if (x_rd_en) x_rd_data <= x_mem[x_addr];
    if (mac_clear)       mac_acc <= '0;
    else if (mac_enable) mac_acc <= mac_acc + ACC_W'(mac_a) * ACC_W'(mac_b);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int unsigned dot(input int n, input int wb, input int xb);
    int unsigned sum = 0;
    for (int i = 0; i < n; i++)
      sum += int'(w_mem[(wb + i) % MEM_SZ]) * int'(x_mem[(xb + i) % MEM_SZ]);
    return sum;
  endfunction

  // Reference model: a job is a cycle offset t from the accept cycle.
  bit          active     = 0;
  bit          post_reset = 0;
  int          t, m_n, m_wb, m_xb, rd_count;
  int unsigned m_exp;
  bit          m_cl;

  always @(negedge clk) begin
    bit e_rd, e_en, e_clr, e_val;
    int valid_t;
    if (reset) begin
      check("mac_clear_in_reset", mac_clear, 1);
      active     = 0;
      post_reset = 1;
    end else if (!active) begin
      check("idle_busy", busy, 0);
      check("idle_w_rd_en", w_rd_en, 0);
      check("idle_x_rd_en", x_rd_en, 0);
      check("idle_mac_enable", mac_enable, 0);
      check("idle_mac_clear", mac_clear, 0);
      check("idle_result_valid", rif.result_valid, 0);
      if (post_reset) begin
        check("reset_w_addr", w_addr, 0);
        check("reset_x_addr", x_addr, 0);
        check("reset_result_data", rif.result_data, 0);
        check("reset_result_clamped", rif.result_clamped, 0);
        post_reset = 0;
      end
      if (start) begin
        active   = 1;
        t        = 0;
        m_n      = (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
        m_cl     = int'(len) > MAX_LEN;
        m_wb     = int'(w_base);
        m_xb     = int'(x_base);
        m_exp    = dot(m_n, m_wb, m_xb);
        rd_count = 0;
      end
    end else begin
      t++;
      e_rd    = (t >= 1) && (t <= m_n);
      e_en    = (m_n > 0) && (t >= 2) && (t <= m_n + 1);
      e_clr   = (m_n > 0) && (t == 1);
      valid_t = (m_n == 0) ? 1 : m_n + 3;
      e_val   = (t >= valid_t);
      if (w_rd_en) rd_count++;
      check("busy", busy, 1);
      check("w_rd_en", w_rd_en, e_rd);
      check("x_rd_en", x_rd_en, e_rd);
      if (e_rd) begin
        check("w_addr", w_addr, (m_wb + t - 1) % MEM_SZ);
        check("x_addr", x_addr, (m_xb + t - 1) % MEM_SZ);
      end
      check("mac_enable", mac_enable, e_en);
      check("mac_clear", mac_clear, e_clr);
      check("result_valid", rif.result_valid, e_val);
      if (e_val) begin
        check("result_data", rif.result_data, m_exp);
        check("result_clamped", rif.result_clamped, m_cl);
        if (rif.result_ready) active = 0;
      end
    end
  end

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) begin @(posedge clk); #1; end
    reset = 1'b0;
  endtask

  // Runs one job from the current post-edge phase; lit_* < 0 means no pin.
  task automatic run_job(input int l, input int wb, input int xb, input int rdy_wait,
                         input int lit_data, input int lit_lat);
    int k = 0;
    bit seen = 0;
    while (busy && k < 1000) begin @(posedge clk); #1; k++; end
    start  = 1'b1;
    len    = LEN_W'(l);
    w_base = ADDR_W'(wb);
    x_base = ADDR_W'(xb);
    @(posedge clk); #1;
    start = 1'b0;
    len   = LEN_W'($urandom);
    for (k = 1; k <= 400; k++) begin
      if (rif.result_valid) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    if (!seen) begin
      check("result_valid_timeout", rif.result_valid, 1);
      do_reset(2);
      return;
    end
    if (lit_lat >= 0)  check("latency_cycles", k, lit_lat);
    if (lit_data >= 0) check("result_literal", rif.result_data, lit_data);
    repeat (rdy_wait) begin
      start = 1'($urandom_range(0, 1));
      len   = LEN_W'($urandom_range(0, 20));
      @(posedge clk); #1;
    end
    start            = 1'b0;
    rif.result_ready = 1'b1;
    @(posedge clk); #1;
    rif.result_ready = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < MEM_SZ; i++) begin
      w_mem[i] = 8'($urandom);
      x_mem[i] = 8'($urandom);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset            = 1'b1;
    start            = 1'b0;
    len              = '0;
    w_base           = '0;
    x_base           = '0;
    rif.result_ready = 1'b0;
    fill_random();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    w_mem[10] = 15;  w_mem[11] = 25;  w_mem[12] = 100;
    x_mem[40] = 10;  x_mem[41] = 20;  x_mem[42] = 50;
    run_job(3, 10, 40, 0, 5650, 6);

    w_mem[0] = 255;  x_mem[100] = 200;
    run_job(1, 0, 100, 1, 51000, 4);

    for (int i = 0; i < MEM_SZ; i++) begin w_mem[i] = 8'hff; x_mem[i] = 8'hff; end
    run_job(256, 0, 0, 0, 16646400, 259);
    check("reads_len256", rd_count, 256);
    run_job(300, 7, 9, 0, 16646400, 259);
    check("reads_len300", rd_count, 256);
    check("clamped_len300", rif.result_clamped, 1);

    fill_random();
    run_job(5, 3, 200, 5, -1, 8);

    // Abandon a len=8 job with a one-cycle reset in its fifth cycle.
    start = 1'b1; len = 8; w_base = 20; x_base = 30;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("busy_after_abort", busy, 0);
    check("valid_after_abort", rif.result_valid, 0);
    w_mem[50] = 3; w_mem[51] = 4; x_mem[60] = 5; x_mem[61] = 6;
    run_job(2, 50, 60, 0, 39, 5);

    fill_random();
    run_job(4, 254, 0, 0, -1, 7);
    run_job(0, 5, 5, 2, 0, 1);

    repeat (25) begin
      int l;
      fill_random();
      l = ($urandom_range(0, 9) == 0) ? $urandom_range(257, 511) : $urandom_range(0, 20);
      run_job(l, $urandom_range(0, MEM_SZ - 1), $urandom_range(0, MEM_SZ - 1),
              $urandom_range(0, 3), -1, -1);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mac_dot_sequencer.md
# mac_dot_sequencer

Controller that runs one dot product on the 8-bit `mac` datapath. It takes a job (length plus two base addresses), fetches operand pairs from a weight memory and an activation memory (both 1-cycle read latency), and drives the MAC's reset, enable and operand inputs one element per cycle. It then returns the 24-bit accumulated result over a valid/ready handshake. It sits between the layer scheduler and a single `mac` instance.

## Interface
Parameters:
- `ADDR_W`, default 8: width of the weight and activation memory addresses.
- `MAX_LEN`, default 256: maximum vector length. Must be ≤ 258 so the 24-bit accumulator cannot overflow.
- `LEN_W`, default 9: width of `len`. Must hold `MAX_LEN`.

Ports (clock and reset first):
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: job request; sampled only in IDLE.
- `len` in LEN_W: number of elements in the job.
- `w_base` in ADDR_W: first weight address; latched on start.
- `x_base` in ADDR_W: first activation address; latched on start.
- `busy` out 1: high in every state except IDLE.
- `w_rd_en` out 1: weight memory read enable.
- `w_addr` out ADDR_W: weight memory read address.
- `w_rd_data` in 8: weight read data, valid the cycle after `w_rd_en`.
- `x_rd_en` out 1: activation memory read enable.
- `x_addr` out ADDR_W: activation memory read address.
- `x_rd_data` in 8: activation read data, valid the cycle after `x_rd_en`.
- `mac_clear` out 1: drives `mac.reset`.
- `mac_enable` out 1: drives `mac.enable`.
- `mac_a` out 8: equals `w_rd_data`.
- `mac_b` out 8: equals `x_rd_data`.
- `mac_out` in 24: MAC accumulator.
- `result_valid` out 1: result available.
- `result_ready` in 1: consumer accepts the result.
- `result_data` out 24: dot-product result.
- `result_clamped` out 1: the requested `len` exceeded `MAX_LEN`.

## Operation
- States: IDLE, CLEAR, RUN, LAST, DRAIN, DONE.
- IDLE:
  - `start=1` with `len=0`: go to DONE, `result_data=0`, no reads issued.
  - `start=1` with `len>0`: latch `n = min(len, MAX_LEN)`, latch both bases, set `result_clamped = (len > MAX_LEN)`, go to CLEAR.
- CLEAR (one cycle): `mac_clear=1`; issue read of element 0 (`rd_en=1`, addr = base). Next state is RUN if n>1, otherwise LAST.
- RUN (n−1 cycles): issue reads of elements 1..n−1, one per cycle. Go to LAST after element n−1 is issued.
- LAST (one cycle): no read issued; the MAC consumes element n−1.
- `mac_enable` is `rd_en` delayed by one cycle, so each pair is accumulated in the cycle its data arrives.
- DRAIN (one cycle): `mac_enable=0`; `result_data <= mac_out`.
- DONE:
  - `result_valid=1`; `result_data` and `result_clamped` are held stable.
  - `result_ready=1` completes the transfer; go to IDLE next cycle.
- `start` outside IDLE is ignored, including in DONE. No queueing.
- Addresses: `base + i`, modulo 2^ADDR_W. Wrap-around is legal and silent.
- `w_rd_en` and `x_rd_en` are always equal; `w_addr` and `x_addr` advance together.
- Arithmetic: the MAC accumulates unsigned 8×8→16 products into 24 bits. Maximum result is 256·65025 = 16 646 400, so no overflow is possible.
- `mac_clear = reset | (state == CLEAR)`, so reset also clears the MAC.
- Reset mid-job: next state IDLE; the job is abandoned and no result is produced.

## Timing
- Start accepted at cycle 0 (`len>0`):
  - `mac_clear` asserted at cycle 1.
  - Reads issued at cycles 1..n.
  - `mac_enable` high at cycles 2..n+1.
  - DRAIN at cycle n+2.
  - `result_valid` from cycle n+3.
- `len=0`: `result_valid` at cycle 1.
- Throughput: one element per cycle. Fixed overhead is 3 cycles plus handshake wait.
- All outputs except `mac_a`, `mac_b` and the reset term of `mac_clear` are registered.
- Reset values: state IDLE; `busy`, `rd_en`, `mac_enable`, `result_valid`, `result_clamped` = 0; addresses 0; `result_data` 0; `mac_clear` = 1 while reset is high.
- `result_valid` and `result_ready` both high in the same cycle is a transfer. `busy` drops the following cycle, and `start` is accepted in that cycle.

## Structure
- Shared package `nn_pkg`:
  - state enum `mac_seq_state_t`
  - `DATA_W=8`, `ACC_W=24`
  - `MAC_SAFE_MAX_LEN=258`
- One sub-module, `mac_seq_addr_gen`: latches the bases, holds the element counter, and produces the addresses with wrap-around, `rd_en`, and a last-element flag. The FSM and handshake stay in the top module.
- The `mac` instance is external; it is wired by the parent.

## Test plan
- len=3, w=[15,25,100], x=[10,20,50], start at cycle 0 → `result_valid` at cycle 6, `result_data`=5650, `result_clamped`=0.
- len=1, w=255, x=200 → `mac_clear` at cycle 1, `mac_enable` at cycle 2 only, `result_data`=51000 at cycle 4.
- len=256, all operands 255 → 16 646 400. len=300 → exactly 256 reads, same result, `result_clamped`=1.
- Hold `result_ready` low for 5 cycles in DONE → `result_data` stable, `busy`=1, `start` pulses ignored. Raising ready → IDLE next cycle, and a new start is accepted that cycle.
- len=8 with reset at cycle 4 → at cycle 5 all outputs at reset values, `mac_clear`=1 during reset, no `result_valid`. A follow-up job with len=2, w=[3,4], x=[5,6] → 39.
- ADDR_W=4, w_base=14, x_base=0, len=4 → `w_addr` sequence 14,15,0,1 and `x_addr` 0,1,2,3. len=0 → `result_valid` at cycle 1, result 0, no `rd_en`.
